// File: rtl/pr_timer.sv
// pr_timer: programmable countdown timer on the peripheral bus.
// CTRL (00), PRESET (01), COUNT (10, read-only) are decoded from Addr[3:2].
// One-shot and auto-reload periodic modes; IRQ = IM & irq_flag, registered.
// Optional build macro PR_TIMER_PRESCALE_EN adds the 8-bit prescaler (CTRL[15:8]).
module pr_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        We,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;
  logic        enable_r, enable_nxt_s;
  logic [1:0]  mode_r, mode_nxt_s;
  logic        im_r, im_nxt_s;
  logic [31:0] preset_r, preset_nxt_s;
  logic [31:0] count_r, count_nxt_s;
  logic        irq_flag_r, irq_flag_nxt_s;
  logic        irq_r;
  logic        tick_s;
  logic        ctrl_wr_s;
  logic        preset_wr_s;
  logic        periodic_s;
  logic [7:0]  ps_rd_s;
  logic        unused_s;

  // Only Addr[3:2] is decoded; the bridge has already done chip select.
  assign unused_s    = ^{Addr[31:4], Addr[1:0]};
  assign ctrl_wr_s   = We && (Addr[3:2] == 2'b00);
  assign preset_wr_s = We && (Addr[3:2] == 2'b01);
  assign periodic_s  = (mode_r == 2'b01);
  assign IRQ         = irq_r;

`ifdef PR_TIMER_PRESCALE_EN
  logic [7:0] ps_r, ps_nxt_s;
  logic [7:0] presc_r;

  assign ps_rd_s = ps_r;
  assign tick_s  = (presc_r == ps_r);

  // Prescaler runs only while counting; it is held clear in IDLE, LOAD and INT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_r <= 8'd0;
    end else if (state_r == ST_CNT) begin
      if (tick_s) begin
        presc_r <= 8'd0;
      end else begin
        presc_r <= presc_r + 8'd1;
      end
    end else begin
      presc_r <= 8'd0;
    end
  end
`else
  assign ps_rd_s = 8'd0;
  assign tick_s  = 1'b1;
`endif

  // Next-state logic: timer state machine first, then bus writes override it.
  always_comb begin
    state_nxt_s    = state_r;
    enable_nxt_s   = enable_r;
    mode_nxt_s     = mode_r;
    im_nxt_s       = im_r;
    preset_nxt_s   = preset_r;
    count_nxt_s    = count_r;
    irq_flag_nxt_s = irq_flag_r;
`ifdef PR_TIMER_PRESCALE_EN
    ps_nxt_s       = ps_r;
`endif

    case (state_r)
      ST_IDLE: begin
        if (enable_r) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        count_nxt_s    = preset_r;
        irq_flag_nxt_s = 1'b0;  // ends the single-cycle periodic pulse
        state_nxt_s    = ST_CNT;
      end
      ST_CNT: begin
        if (!enable_r) begin
          state_nxt_s = ST_IDLE;
        end else if (count_r == 32'd0) begin
          state_nxt_s = ST_INT;
        end else if (tick_s) begin
          count_nxt_s = count_r - 32'd1;
          state_nxt_s = ST_CNT;
        end else begin
          state_nxt_s = ST_CNT;
        end
      end
      ST_INT: begin
        irq_flag_nxt_s = 1'b1;
        if (periodic_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          enable_nxt_s = 1'b0;
          state_nxt_s  = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // Bus writes win over whatever the state machine decided this edge;
    // a forced restart or stop also holds COUNT where it is.
    if (ctrl_wr_s) begin
      enable_nxt_s   = Din[0];
      mode_nxt_s     = Din[2:1];
      im_nxt_s       = Din[3];
      irq_flag_nxt_s = 1'b0;
      count_nxt_s    = count_r;
`ifdef PR_TIMER_PRESCALE_EN
      ps_nxt_s       = Din[15:8];
`endif
      if (Din[0]) begin
        state_nxt_s = ST_LOAD;
      end else begin
        state_nxt_s = ST_IDLE;
      end
    end else if (preset_wr_s) begin
      preset_nxt_s = Din;
      if (enable_r) begin
        enable_nxt_s = enable_r;
        count_nxt_s  = count_r;
        state_nxt_s  = ST_LOAD;
      end else begin
        state_nxt_s = state_nxt_s;
      end
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // State and register file update; IRQ is registered from next-cycle values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      enable_r   <= 1'b0;
      mode_r     <= 2'b00;
      im_r       <= 1'b0;
      preset_r   <= 32'd0;
      count_r    <= 32'd0;
      irq_flag_r <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      enable_r   <= enable_nxt_s;
      mode_r     <= mode_nxt_s;
      im_r       <= im_nxt_s;
      preset_r   <= preset_nxt_s;
      count_r    <= count_nxt_s;
      irq_flag_r <= irq_flag_nxt_s;
      irq_r      <= im_nxt_s & irq_flag_nxt_s;
    end
  end

`ifdef PR_TIMER_PRESCALE_EN
  // Prescale value register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_r <= 8'd0;
    end else begin
      ps_r <= ps_nxt_s;
    end
  end
`endif

  // Read mux, combinational from Addr[3:2] so the bridge sees it in the same cycle.
  always_comb begin
    Dout = 32'd0;
    case (Addr[3:2])
      2'b00:   Dout = {16'd0, ps_rd_s, 4'd0, im_r, mode_r, enable_r};
      2'b01:   Dout = preset_r;
      2'b10:   Dout = count_r;
      default: Dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_pr_timer.sv
// Self-checking bench for pr_timer: directed scenarios with literal expectations
// plus randomized bus traffic, all compared every cycle against a behavioural model.
module tb_pr_timer;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic        We;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int checks;
  int failures;
  bit chk_en;

  pr_timer dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .We   (We),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  localparam int S_IDLE = 0, S_LOAD = 1, S_CNT = 2, S_INT = 3;
  int          m_st;
  bit          m_en, m_im, m_flag, m_irq;
  bit [1:0]    m_mode;
  bit [7:0]    m_ps, m_pre;
  bit [31:0]   m_preset, m_count;

  task automatic model_reset();
    m_st = S_IDLE; m_en = 0; m_im = 0; m_flag = 0; m_irq = 0;
    m_mode = 2'd0; m_ps = 8'd0; m_pre = 8'd0; m_preset = 32'd0; m_count = 32'd0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a[3:2])
      2'b00:   return {16'd0, m_ps, 4'd0, m_im, m_mode, m_en};
      2'b01:   return m_preset;
      2'b10:   return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // One rising edge of the timer, applying the rules in plain procedural form.
  task automatic model_edge(input bit w, input logic [31:0] a, input logic [31:0] d);
    int        n_st;
    bit        n_en, n_flag, tick;
    bit [31:0] n_count;
    n_st = m_st; n_en = m_en; n_flag = m_flag; n_count = m_count;
`ifdef PR_TIMER_PRESCALE_EN
    tick = (m_pre == m_ps);
`else
    tick = 1;
`endif
    if (m_st == S_IDLE) begin
      if (m_en) n_st = S_LOAD;
    end else if (m_st == S_LOAD) begin
      n_count = m_preset; n_flag = 0; n_st = S_CNT;
    end else if (m_st == S_CNT) begin
      if (!m_en) n_st = S_IDLE;
      else if (m_count == 0) n_st = S_INT;
      else if (tick) n_count = m_count - 1;
    end else begin
      n_flag = 1;
      if (m_mode == 2'b01) n_st = S_LOAD;
      else begin n_en = 0; n_st = S_IDLE; end
    end
    if (w && a[3:2] == 2'b00) begin
      n_en = d[0]; m_mode = d[2:1]; m_im = d[3]; n_flag = 0; n_count = m_count;
`ifdef PR_TIMER_PRESCALE_EN
      m_ps = d[15:8];
`endif
      n_st = d[0] ? S_LOAD : S_IDLE;
    end else if (w && a[3:2] == 2'b01) begin
      if (m_en) begin n_en = m_en; n_count = m_count; n_st = S_LOAD; end
      m_preset = d;
    end
    m_pre   = (m_st == S_CNT) ? (tick ? 8'd0 : m_pre + 8'd1) : 8'd0;
    m_st    = n_st; m_en = n_en; m_flag = n_flag; m_count = n_count;
    m_irq   = m_im & m_flag;
  endtask

  // ---------------- checking ----------------
  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model, mid low phase.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      cmp("dout_model", Dout, model_read(Addr));
      cmp("irq_model", {31'd0, IRQ}, {31'd0, m_irq});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit w, input bit [1:0] sel, input logic [31:0] d);
    We   = w;
    Addr = ($urandom() & 32'hFFFF_FFF3) | {28'd0, sel, 2'b00};
    Din  = d;
    @(posedge clk);
    if (reset) model_edge(w, Addr, d);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b10, 32'd0);
  endtask

  task automatic peek(input bit [1:0] sel, input logic [31:0] exp, input string name);
    We = 1'b0;
    Addr = {28'd0, sel, 2'b00};
    #1;
    cmp(name, Dout, exp);
  endtask

  int first_pulse, second_pulse;

  initial begin
    checks = 0; failures = 0; chk_en = 1'b1;
    reset = 1'b0; We = 1'b0; Addr = 32'd0; Din = 32'd0;
    model_reset();
    #1;
    peek(2'b00, 32'd0, "rst_ctrl");
    peek(2'b01, 32'd0, "rst_preset");
    peek(2'b10, 32'd0, "rst_count");
    cmp("rst_irq", {31'd0, IRQ}, 32'd0);
    idle(2);
    reset = 1'b1;
    idle(2);

    // One-shot: PRESET=5, CTRL=0x9 at edge k.
    step(1'b1, 2'b01, 32'd5);
    step(1'b1, 2'b00, 32'h9);
    idle(1);
    peek(2'b10, 32'd5, "os_count_k1");
    idle(5);
    peek(2'b10, 32'd0, "os_count_k6");
    idle(1);
    cmp("os_irq_k7", {31'd0, IRQ}, 32'd0);
    idle(1);
    cmp("os_irq_k8", {31'd0, IRQ}, 32'd1);
    peek(2'b00, 32'h8, "os_ctrl_rd");
    idle(3);
    cmp("os_irq_sticky", {31'd0, IRQ}, 32'd1);
    step(1'b1, 2'b00, 32'h8);
    cmp("os_irq_clr", {31'd0, IRQ}, 32'd0);

    // Periodic: PRESET=3, CTRL=0xB -> pulses every 6 cycles.
    step(1'b1, 2'b01, 32'd3);
    step(1'b1, 2'b00, 32'hB);
    first_pulse = -1; second_pulse = -1;
    for (int i = 1; i <= 14; i++) begin
      step(1'b0, 2'b10, 32'd0);
      if (IRQ === 1'b1) begin
        if (first_pulse < 0) first_pulse = i;
        else if (second_pulse < 0) second_pulse = i;
      end
      if (i == 7) peek(2'b10, 32'd3, "per_reload");
    end
    cmp("per_first", first_pulse, 32'd6);
    cmp("per_second", second_pulse, 32'd12);
    step(1'b1, 2'b00, 32'h0);

    // Mask: IM=0 one-shot, then IM=1 write clears the flag.
    step(1'b1, 2'b01, 32'd2);
    step(1'b1, 2'b00, 32'h1);
    idle(7);
    cmp("mask_irq", {31'd0, IRQ}, 32'd0);
    peek(2'b00, 32'h0, "mask_ctrl");
    step(1'b1, 2'b00, 32'h8);
    idle(1);
    cmp("mask_irq_im", {31'd0, IRQ}, 32'd0);

    // Freeze: CTRL=0 mid-count holds COUNT.
    step(1'b1, 2'b00, 32'h0);
    step(1'b1, 2'b01, 32'd10);
    step(1'b1, 2'b00, 32'h1);
    idle(6);
    peek(2'b10, 32'd5, "frz_before");
    step(1'b1, 2'b00, 32'h0);
    peek(2'b10, 32'd5, "frz_at");
    idle(3);
    peek(2'b10, 32'd5, "frz_hold");

    // Collision: CTRL=0x9 on the edge that leaves INT.
    step(1'b1, 2'b01, 32'd2);
    step(1'b1, 2'b00, 32'h9);
    idle(4);
    step(1'b1, 2'b00, 32'h9);
    peek(2'b00, 32'h9, "col_ctrl");
    cmp("col_irq", {31'd0, IRQ}, 32'd0);
    idle(1);
    peek(2'b10, 32'd2, "col_reload");
    step(1'b1, 2'b00, 32'h0);

    // Prescaler readback and behaviour.
    step(1'b1, 2'b00, 32'h0000_0309);
`ifdef PR_TIMER_PRESCALE_EN
    peek(2'b00, 32'h0000_0309, "ps_rd");
`else
    peek(2'b00, 32'h0000_0009, "ps_rd");
`endif
    idle(16);
    step(1'b1, 2'b00, 32'h0);

    // Reset mid-count: PRESET=100, stop at COUNT=40.
    step(1'b1, 2'b01, 32'd100);
    step(1'b1, 2'b00, 32'h1);
    idle(61);
    peek(2'b10, 32'd40, "rmid_count40");
    reset = 1'b0;
    model_reset();
    #1;
    cmp("rmid_count0", Dout, 32'd0);
    cmp("rmid_irq", {31'd0, IRQ}, 32'd0);
    idle(2);
    reset = 1'b1;
    idle(5);
    peek(2'b10, 32'd0, "rmid_nocount");
    peek(2'b00, 32'd0, "rmid_ctrl");

    // Randomized bus traffic.
    for (int i = 0; i < 800; i++) begin
      bit [1:0]    sel;
      logic [31:0] d;
      sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        case (sel)
          2'b00:   d = {16'd0, 8'($urandom_range(0, 2)), 4'd0, 4'($urandom())};
          2'b01:   d = 32'($urandom_range(0, 10));
          default: d = $urandom();
        endcase
        step(1'b1, sel, d);
      end else begin
        step(1'b0, sel, 32'd0);
      end
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pr_timer.md
# pr_timer

Programmable countdown timer that sits on the processor-side peripheral bus as a bus responder. The CPU drives it through the bridge with address, write-enable and write data, and reads registers back over the read-data path. It raises one of the CPU's hardware interrupt lines (`HWInt`) when a countdown completes. It supports a one-shot mode and an auto-reload periodic mode.

## Interface
Parameters: none.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low. While 0, every register and output is cleared immediately.
- `Addr` in 32: byte address from the bridge. Only `Addr[3:2]` is decoded; the bridge has already done chip select.
- `We` in 1: write enable, qualified by the bridge chip select.
- `Din` in 32: write data.
- `Dout` out 32: read data, combinational from `Addr[3:2]`.
- `IRQ` out 1: registered interrupt request, routed to one `HWInt` bit.

## Operation
Register map (word access only):
- `Addr[3:2]`=00, CTRL (read/write):
  - [0] Enable.
  - [2:1] Mode: 00 one-shot, 01 periodic, 1x treated as 00.
  - [3] IM, interrupt mask.
  - [15:8] PS (see Configuration).
  - All other bits read 0.
- `Addr[3:2]`=01, PRESET (read/write, 32 bits).
- `Addr[3:2]`=10, COUNT (read-only; writes are ignored).
- `Addr[3:2]`=11: reads 0; writes are ignored.

State machine states: IDLE, LOAD, CNT, INT.
- IDLE:
  - Moves to LOAD when Enable=1.
  - Otherwise holds; COUNT keeps its value.
- LOAD: COUNT <= PRESET, then move to CNT.
- CNT:
  - If Enable=0, move to IDLE with COUNT frozen.
  - Else if COUNT==0, move to INT.
  - Else on each tick, COUNT <= COUNT-1. Unsigned arithmetic; no wrap, because zero exits the state.
- INT:
  - Mode 00: `irq_flag` <= 1, Enable <= 0, move to IDLE. `irq_flag` is sticky until any CTRL write.
  - Mode 01: `irq_flag` <= 1 for exactly one cycle, then move to LOAD.
- `IRQ` = IM & `irq_flag`, registered.

Write rules:
- Any CTRL write clears `irq_flag`.
- A CTRL write with Enable=1, or a PRESET write while Enable=1, forces the next state to LOAD (restart) from any state.
- A CTRL write with Enable=0 forces IDLE.
- A bus write wins over the state-machine update in the same cycle. This includes INT clearing Enable, and the `irq_flag` set-vs-clear in the same edge.
- PRESET=0: LOAD loads 0; CNT sees 0 on the following edge and moves to INT.

## Timing
Reset values: `Dout` reflects all-zero registers; `IRQ`=0; state IDLE; CTRL, PRESET, COUNT and `irq_flag` all 0.

Tick is every cycle when the prescaler is compiled out. With PRESET=N, Enable written at edge k:
- Edge k+1: LOAD executes (COUNT=N).
- Edges k+2 to k+N+1: decrements.
- Edge k+N+2: enter INT.
- Edge k+N+3: `irq_flag` set.
- `IRQ` is high from edge k+N+3, given IM=1.

Periodic mode: period is N+3 cycles between `IRQ` pulses.

`Dout` tracks register contents combinationally in the same cycle as `Addr`, so the bridge captures it into the CPU's memory-stage read path.

Reset asserted mid-count: everything returns to the reset values immediately, with no pending interrupt.

## Configuration
`PR_TIMER_PRESCALE_EN`:
- Defined:
  - CTRL[15:8] PS is writable and readable.
  - An 8-bit prescaler counter produces one tick every PS+1 cycles.
  - The prescaler counter clears on entry to LOAD and in IDLE.
- Undefined:
  - CTRL[15:8] reads 0 and writes to it are ignored.
  - Tick occurs every cycle.

## Test plan
- Reset low mid-count (PRESET=100, COUNT=40) -> COUNT=0, `IRQ`=0, state IDLE immediately; after reset rises, no count occurs until a CTRL write.
- One-shot: PRESET=5, then CTRL=0x9 (Enable, IM) at edge k -> COUNT reads 5 after k+1, 0 after k+6; `IRQ`=1 from k+8; CTRL reads 0x8; `IRQ` stays 1 until CTRL is written with 0x8, then drops at the next edge.
- Periodic: PRESET=3, CTRL=0xB -> `IRQ` pulses one cycle wide, repeating every 6 cycles; COUNT reloads to 3 after each pulse.
- Mask and freeze: one-shot with IM=0 -> `IRQ` stays 0 while `irq_flag` is set internally. Setting IM=1 is a CTRL write, which clears the flag, so `IRQ` stays 0. Writing CTRL=0 mid-count freezes COUNT at its current value.
- Collision: a CTRL write of 0x9 on the same edge the state machine leaves INT -> the write wins; Enable stays 1, `irq_flag` stays 0, and the count restarts from PRESET.
- With `PR_TIMER_PRESCALE_EN`: PS=3, PRESET=2 -> COUNT decrements once every 4 cycles; CTRL reads back 0x0309 after writing 0x0309. Without the macro, the same write reads back 0x0009.
